// File: rtl/adder_error_metric.sv
// Streaming error-distance accumulator for exact vs approximate adders.
// Runs over N samples, then holds count, error count, ED sum and max ED.
module adder_error_metric #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = WIDTH + 1 + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   exact_sum,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] acc_q;
  logic             s1_vld;
  logic [WIDTH:0]   s1_ed;
  logic [WIDTH:0]   ed;
  logic [CNT_W-1:0] cnt_inc;
  logic             go;
  logic             xfer;
  logic             s2_last;

  assign go       = start && (state_q != RUN);
  assign in_ready = (state_q == RUN) && (acc_q != n_q);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign cnt_inc  = sample_count + CNT_W'(1);
  assign s2_last  = s1_vld && (cnt_inc == n_q);

  // Both operands are WIDTH+1 bits, so ordering the subtraction
  // keeps the magnitude exact with no wrap.
  assign ed = (exact_sum >= approx_sum) ?
              (exact_sum - approx_sum) :
              (approx_sum - exact_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      go: begin
        if (num_samples != '0) state_d = RUN;
        else                   state_d = DONE;
      end
      s2_last && (state_q == RUN): state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q          <= '0;
      acc_q        <= '0;
      s1_vld       <= 1'b0;
      s1_ed        <= '0;
      sample_count <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else if (go) begin
      n_q          <= num_samples;
      acc_q        <= '0;
      s1_vld       <= 1'b0;
      s1_ed        <= '0;
      sample_count <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_ed <= ed;
        acc_q <= acc_q + CNT_W'(1);
      end
      if (s1_vld) begin
        sample_count <= cnt_inc;
        if (s1_ed != '0) err_count <= err_count + CNT_W'(1);
        sum_ed <= sum_ed + ACC_W'(s1_ed);
        if (s1_ed > max_ed) max_ed <= s1_ed;
      end
    end
  end

endmodule

// File: tb/tb_adder_error_metric.sv
// Scoreboard bench for adder_error_metric.
// Directed vectors; a negedge monitor checks per-sample ED and final results.
module tb_adder_error_metric;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] exact_sum;
  logic [16:0] approx_sum;
  logic        busy;
  logic        done;
  logic [15:0] sample_count;
  logic [15:0] err_count;
  logic [32:0] sum_ed;
  logic [16:0] max_ed;

  typedef struct packed {
    logic [15:0] c;
    logic [15:0] e;
    logic [32:0] s;
    logic [16:0] m;
  } res_t;

  res_t        res_q[$];
  logic [16:0] ed_q[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] prev_cnt = '0;
  logic [32:0] prev_sum = '0;
  logic        prev_done = 1'b0;

  adder_error_metric dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exact_sum    (exact_sum),
    .approx_sum   (approx_sum),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .sum_ed       (sum_ed),
    .max_ed       (max_ed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: ED per accumulated sample, full result on done rising.
  always @(negedge clk) begin
    if (rst_n) begin
      if ({16'd0, sample_count} == {16'd0, prev_cnt} + 32'd1) begin
        if (ed_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ed_unexpected: got sample %0d expected none",
                   sample_count);
        end else begin
          logic [16:0] e;
          e = ed_q.pop_front();
          chk("ed", 64'(sum_ed - prev_sum), 64'(e));
        end
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done 1 expected 0");
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("res_count", 64'(sample_count), 64'(r.c));
          chk("res_err", 64'(err_count), 64'(r.e));
          chk("res_sum", 64'(sum_ed), 64'(r.s));
          chk("res_max", 64'(max_ed), 64'(r.m));
        end
      end
    end
    prev_cnt  = sample_count;
    prev_sum  = sum_ed;
    prev_done = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [16:0] e,
                      input logic [16:0] a,
                      input logic [16:0] ed);
    int t;
    t = 0;
    exact_sum = e;
    approx_sum = a;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      ed_q.push_back(ed);
      step();
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done 0 expected 1");
    end
    idle(1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_cnt"}, 64'(sample_count), 0);
    chk({nm, "_err"}, 64'(err_count), 0);
    chk({nm, "_sum"}, 64'(sum_ed), 0);
    chk({nm, "_max"}, 64'(max_ed), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    exact_sum = '0;
    approx_sum = '0;

    // Reset with random inputs
    repeat (3) begin
      start = 1'($urandom);
      in_valid = 1'($urandom);
      num_samples = 16'($urandom);
      exact_sum = 17'($urandom);
      approx_sum = 17'($urandom);
      step();
      chk("rst_ready", 64'(in_ready), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk_zero("rst");
    end
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    chk("idle_busy", 64'(busy), 0);
    chk("idle_done", 64'(done), 0);
    chk("idle_ready", 64'(in_ready), 0);

    // N = 0
    res_q.push_back('{16'd0, 16'd0, 33'd0, 17'd0});
    start_run(16'd0);
    chk("n0_done", 64'(done), 1);
    chk("n0_busy", 64'(busy), 0);
    in_valid = 1'b1;
    exact_sum = 17'd9;
    approx_sum = 17'd1;
    repeat (3) begin
      chk("n0_ready", 64'(in_ready), 0);
      step();
    end
    chk_zero("n0");
    idle(1);

    // Basic run, in_valid held high
    res_q.push_back('{16'd4, 16'd3, 33'd65538, 17'd65535});
    start_run(16'd4);
    chk("basic_busy", 64'(busy), 1);
    chk("basic_ready", 64'(in_ready), 1);
    chk("basic_done0", 64'(done), 0);
    send(17'd3, 17'd3, 17'd0);
    send(17'd30, 17'd31, 17'd1);
    send(17'd10, 17'd8, 17'd2);
    send(17'd65535, 17'd0, 17'd65535);
    in_valid = 1'b0;
    chk("basic_last_ready", 64'(in_ready), 0);
    chk("basic_last_done", 64'(done), 0);
    step();
    chk("basic_done1", 64'(done), 1);
    chk("basic_busy0", 64'(busy), 0);
    idle(1);

    // Gapped input
    res_q.push_back('{16'd3, 16'd2, 33'd131072, 17'd131071});
    start_run(16'd3);
    send(17'd5, 17'd4, 17'd1);
    idle(1);
    send(17'd0, 17'd131071, 17'd131071);
    idle(2);
    send(17'd7, 17'd7, 17'd0);
    exact_sum = 17'd100;
    approx_sum = 17'd0;
    in_valid = 1'b1;
    chk("gap_extra_ready", 64'(in_ready), 0);
    chk("gap_extra_busy", 64'(busy), 1);
    repeat (3) step();
    chk("gap_done", 64'(done), 1);
    chk("gap_hold_sum", 64'(sum_ed), 131072);
    chk("gap_hold_cnt", 64'(sample_count), 3);
    chk("gap_hold_ready", 64'(in_ready), 0);
    idle(1);

    // Reset mid-run
    start_run(16'd4);
    send(17'd1, 17'd2, 17'd1);
    send(17'd4, 17'd2, 17'd2);
    idle(2);
    chk("mid_cnt", 64'(sample_count), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_done", 64'(done), 0);
    chk("mid_rst_ready", 64'(in_ready), 0);
    chk_zero("mid_rst");
    ed_q.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("mid_idle_busy", 64'(busy), 0);

    // N = 1 with an ignored start during RUN
    res_q.push_back('{16'd1, 16'd1, 33'd7, 17'd7});
    start_run(16'd1);
    start_run(16'd5);
    chk("ign_busy", 64'(busy), 1);
    chk("ign_ready", 64'(in_ready), 1);
    send(17'd2, 17'd9, 17'd7);
    in_valid = 1'b0;
    wait_done();

    // Restart from DONE
    res_q.push_back('{16'd2, 16'd0, 33'd0, 17'd0});
    start_run(16'd2);
    chk("rs_done", 64'(done), 0);
    chk("rs_busy", 64'(busy), 1);
    chk_zero("rs_clear");
    send(17'd1, 17'd1, 17'd0);
    send(17'd1, 17'd1, 17'd0);
    in_valid = 1'b0;
    wait_done();
    idle(2);

    chk("res_q_left", 64'(res_q.size()), 0);
    chk("ed_q_left", 64'(ed_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
